// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the register-bus arbiter slice.
package reg_bus_arbiter_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Read data handed back when the register bus never acknowledges
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic with a last-grant register.
module rr_arb2 (
    input  logic       core_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant
);

    logic last_grant;

    // Lone requester wins; on contention the one not served last wins
    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

    // Remember who was served; reset to 1 so requester 0 wins first
    always_ff @(posedge core_clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the register-access bus between two show-ahead request FIFOs,
// round-robin, with a req/ack handshake guarded by a timeout.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int unsigned         ADDR_W       = 27,
    parameter int unsigned         DATA_W       = 32,
    parameter int unsigned         TIMEOUT      = 255,
    parameter logic [DATA_W-1:0]   TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEFAULT)
) (
    input  logic              core_clk,
    input  logic              reset,
    input  logic              p0_empty,
    output logic              p0_rd_en,
    input  logic              p0_rd_wr_L,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    output logic [DATA_W-1:0] p0_rd_data,
    output logic              p0_rd_vld,
    input  logic              p1_empty,
    output logic              p1_rd_en,
    input  logic              p1_rd_wr_L,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              p1_rd_vld,
    output logic              reg_req,
    output logic              reg_rd_wr_L,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_src,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              timeout_pulse,
    output logic [15:0]       timeout_cnt
);

    localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

    arb_state_t  state, state_nxt;
    logic [15:0] wait_cnt;
    logic        grant_valid;
    logic        grant;
    logic        grant_cycle;
    logic        timeout_hit;

    // No grant while reset is held so nothing is popped and then dropped
    assign grant_cycle = (state == IDLE) && grant_valid && !reset;
    assign timeout_hit = (state == REQ) && !reg_ack && (wait_cnt == TERM);

    rr_arb2 u_rr_arb2 (
        .core_clk    (core_clk),
        .reset       (reset),
        .req         ({~p1_empty, ~p0_empty}),
        .advance     (grant_cycle),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: grant -> wait for ack or timeout -> one response cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_cycle) state_nxt = REQ;
            REQ:     if (reg_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pops in IDLE, request in REQ, read strobe in RESP
    always_comb begin
        p0_rd_en  = grant_cycle && !grant;
        p1_rd_en  = grant_cycle && grant;
        reg_req   = (state == REQ);
        busy      = (state != IDLE);
        p0_rd_vld = (state == RESP) && reg_rd_wr_L && !reg_src;
        p1_rd_vld = (state == RESP) && reg_rd_wr_L && reg_src;
    end

    // Transaction latch, wait counter, read-data return and timeout stats
    always_ff @(posedge core_clk) begin
        if (reset) begin
            reg_rd_wr_L   <= 1'b0;
            reg_addr      <= '0;
            reg_wr_data   <= '0;
            reg_src       <= 1'b0;
            wait_cnt      <= '0;
            timeout_pulse <= 1'b0;
            timeout_cnt   <= '0;
            p0_rd_data    <= '0;
            p1_rd_data    <= '0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (grant_cycle) begin
                reg_rd_wr_L <= grant ? p1_rd_wr_L : p0_rd_wr_L;
                reg_addr    <= grant ? p1_addr    : p0_addr;
                reg_wr_data <= grant ? p1_wr_data : p0_wr_data;
                reg_src     <= grant;
                wait_cnt    <= '0;
            end
            if (state == REQ) begin
                // Response data goes straight into the owner's output
                // register, so it is already valid during RESP and holds
                // until that source's next read completes.
                if (reg_ack) begin
                    if (reg_rd_wr_L && !reg_src) p0_rd_data <= reg_rd_data;
                    if (reg_rd_wr_L &&  reg_src) p1_rd_data <= reg_rd_data;
                end else if (timeout_hit) begin
                    if (reg_rd_wr_L && !reg_src) p0_rd_data <= TIMEOUT_DATA;
                    if (reg_rd_wr_L &&  reg_src) p1_rd_data <= TIMEOUT_DATA;
                    if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 16'd1;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end
        end
    end

endmodule
